// File: rtl/mov_bus_responder.sv
// Datapath responder for the MOV sequencer: general register bank, I0/I1 ports and
// a registered bus-hold value replacing the tristate bus, with contention/address flags.
module mov_bus_responder #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] register_addr,
  input  logic              bus_register_out_en,
  input  logic              bus_register_input_en,
  input  logic              I0_bus_output_en,
  input  logic              I0_bus_input_en,
  input  logic              I1_bus_output_en,
  input  logic [DATA_W-1:0] io0_in,
  input  logic [DATA_W-1:0] io1_in,
  output logic [DATA_W-1:0] io0_out,
  output logic              io0_strobe,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_error,
  output logic              addr_error,
  input  logic              err_clear,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  // Number of asserted source enables; more than one means bus contention.
  function automatic logic [1:0] count_active(input logic [2:0] en);
    count_active = {1'b0, en[0]} + {1'b0, en[1]} + {1'b0, en[2]};
  endfunction

  logic [DATA_W-1:0] bank_r [NUM_REGS];
  logic [DATA_W-1:0] bus_hold_r;
  logic [DATA_W-1:0] io0_out_r;
  logic [DATA_W-1:0] io0_smp_r;
  logic [DATA_W-1:0] io1_smp_r;
  logic [2:0]        src_en_d_r;
  logic              in_en_d_r;
  logic              io0_strobe_r;
  logic              bus_error_r;
  logic              addr_error_r;

  logic [2:0]        src_en_s;
  logic [2:0]        src_rise_s;
  logic [1:0]        src_cnt_s;
  logic              addr_ok_s;
  logic              bank_access_s;
  logic [IDX_W-1:0]  addr_idx_s;
  logic [IDX_W-1:0]  dbg_idx_s;
  logic [DATA_W-1:0] bank_rd_s;
  logic [DATA_W-1:0] bus_next_s;
  logic [DATA_W-1:0] dbg_data_s;

  // Bit 0 = bank, bit 1 = I0 input register, bit 2 = I1 input register.
  assign src_en_s      = {I1_bus_output_en, I0_bus_output_en, bus_register_out_en};
  assign src_rise_s    = src_en_s & ~src_en_d_r;
  assign src_cnt_s     = count_active(src_en_s);
  assign addr_ok_s     = (register_addr < NUM_REGS_A);
  assign bank_access_s = bus_register_out_en | bus_register_input_en;
  assign addr_idx_s    = register_addr[IDX_W-1:0];
  assign dbg_idx_s     = dbg_addr[IDX_W-1:0];

  // Bank read port for the bus source; out-of-range addresses read as zero.
  always_comb begin
    bank_rd_s = {DATA_W{1'b0}};
    if (addr_ok_s) begin
      bank_rd_s = bank_r[addr_idx_s];
    end else begin
      bank_rd_s = {DATA_W{1'b0}};
    end
  end

  // Next bus value: capture only on the rising edge of a lone source enable, else hold.
  always_comb begin
    bus_next_s = bus_hold_r;
    if (src_cnt_s == 2'd1) begin
      case (src_rise_s)
        3'b001:  bus_next_s = bank_rd_s;
        3'b010:  bus_next_s = io0_smp_r;
        3'b100:  bus_next_s = io1_smp_r;
        default: bus_next_s = bus_hold_r;
      endcase
    end else begin
      bus_next_s = bus_hold_r;
    end
  end

  // Debug read port into the bank.
  always_comb begin
    dbg_data_s = {DATA_W{1'b0}};
    if (dbg_addr < NUM_REGS_A) begin
      dbg_data_s = bank_r[dbg_idx_s];
    end else begin
      dbg_data_s = {DATA_W{1'b0}};
    end
  end

  // General register bank; the write takes the forwarded bus value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_r[i] <= {DATA_W{1'b0}};
      end
    end else if (bus_register_input_en && addr_ok_s) begin
      bank_r[addr_idx_s] <= bus_next_s;
    end
  end

  // Pin sampling, enable edge tracking, bus hold, I0 output and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      io0_smp_r    <= {DATA_W{1'b0}};
      io1_smp_r    <= {DATA_W{1'b0}};
      src_en_d_r   <= 3'b000;
      in_en_d_r    <= 1'b0;
      bus_hold_r   <= {DATA_W{1'b0}};
      io0_out_r    <= {DATA_W{1'b0}};
      io0_strobe_r <= 1'b0;
      bus_error_r  <= 1'b0;
      addr_error_r <= 1'b0;
    end else begin
      io0_smp_r    <= io0_in;
      io1_smp_r    <= io1_in;
      src_en_d_r   <= src_en_s;
      in_en_d_r    <= I0_bus_input_en;
      bus_hold_r   <= bus_next_s;
      io0_strobe_r <= I0_bus_input_en & ~in_en_d_r;
      if (I0_bus_input_en) begin
        io0_out_r <= bus_next_s;
      end
      // A fresh error in the clearing cycle keeps the flag set.
      if (src_cnt_s > 2'd1) begin
        bus_error_r <= 1'b1;
      end else if (err_clear) begin
        bus_error_r <= 1'b0;
      end
      if (bank_access_s && !addr_ok_s) begin
        addr_error_r <= 1'b1;
      end else if (err_clear) begin
        addr_error_r <= 1'b0;
      end
    end
  end

  assign io0_out    = io0_out_r;
  assign io0_strobe = io0_strobe_r;
  assign bus_data   = bus_hold_r;
  assign bus_error  = bus_error_r;
  assign addr_error = addr_error_r;
  assign dbg_data   = dbg_data_s;

endmodule

// File: tb/tb_mov_bus_responder.sv
// Scoreboard bench for mov_bus_responder: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them.
module tb_mov_bus_responder;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] register_addr;
  logic              bus_register_out_en, bus_register_input_en;
  logic              I0_bus_output_en, I0_bus_input_en, I1_bus_output_en;
  logic [DATA_W-1:0] io0_in, io1_in;
  logic [DATA_W-1:0] io0_out, bus_data, dbg_data;
  logic              io0_strobe, bus_error, addr_error, err_clear;
  logic [ADDR_W-1:0] dbg_addr;

  mov_bus_responder #(.DATA_W(8), .NUM_REGS(5), .ADDR_W(6)) dut (
    .clock(clock), .reset(reset), .register_addr(register_addr),
    .bus_register_out_en(bus_register_out_en), .bus_register_input_en(bus_register_input_en),
    .I0_bus_output_en(I0_bus_output_en), .I0_bus_input_en(I0_bus_input_en),
    .I1_bus_output_en(I1_bus_output_en), .io0_in(io0_in), .io1_in(io1_in),
    .io0_out(io0_out), .io0_strobe(io0_strobe), .bus_data(bus_data),
    .bus_error(bus_error), .addr_error(addr_error), .err_clear(err_clear),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    int          sig;
    logic [7:0]  val;
    string       name;
  } sb_entry_t;

  localparam int S_BUS = 0, S_IO0 = 1, S_STB = 2, S_BERR = 3, S_AERR = 4, S_DBG = 5;

  sb_entry_t sb_q[$];
  sb_entry_t mon_e;
  int        cyc_cnt = 0;
  int        n_tests = 0;
  int        n_fail  = 0;
  logic [7:0] act;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [7:0] sample(input int sig);
    case (sig)
      S_BUS:   sample = bus_data;
      S_IO0:   sample = io0_out;
      S_STB:   sample = {7'd0, io0_strobe};
      S_BERR:  sample = {7'd0, bus_error};
      S_AERR:  sample = {7'd0, addr_error};
      S_DBG:   sample = dbg_data;
      default: sample = 8'hxx;
    endcase
  endfunction

  // Monitor: pop every expectation due this cycle and compare against the DUT.
  always @(negedge clock) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
      mon_e = sb_q.pop_front();
      n_tests++;
      act = sample(mon_e.sig);
      if (mon_e.cyc != cyc_cnt) begin
        n_fail++;
        $display("FAIL %s: check missed its cycle (due %0d, now %0d)", mon_e.name, mon_e.cyc, cyc_cnt);
      end else if (act !== mon_e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%02h, expected 0x%02h", mon_e.name, act, mon_e.val);
      end
    end
  end

  task automatic chk(input int sig, input logic [7:0] val, input string name);
    sb_q.push_back('{cyc_cnt, sig, val, name});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus_register_out_en   = 1'b0;
    bus_register_input_en = 1'b0;
    I0_bus_output_en      = 1'b0;
    I0_bus_input_en       = 1'b0;
    I1_bus_output_en      = 1'b0;
    err_clear             = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1; register_addr = 6'd0; io0_in = 8'h00; io1_in = 8'h00; dbg_addr = 6'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    dbg_addr = 6'd2;
    chk(S_BUS, 8'h00, "rst_bus"); chk(S_IO0, 8'h00, "rst_io0"); chk(S_STB, 8'h00, "rst_strobe");
    chk(S_BERR, 8'h00, "rst_bus_err"); chk(S_AERR, 8'h00, "rst_addr_err"); chk(S_DBG, 8'h00, "rst_bank2");

    // Preload bank[2]=0x5A through the I1 -> bank path
    io1_in = 8'h5A; io0_in = 8'h77; tick();
    I1_bus_output_en = 1'b1; bus_register_input_en = 1'b1; register_addr = 6'd2; tick();
    chk(S_DBG, 8'h5A, "preload_bank2"); chk(S_BUS, 8'h5A, "preload_bus");
    idle(); tick();

    // I1 -> I0 with strobe
    io1_in = 8'h3C; tick();
    I1_bus_output_en = 1'b1; tick();
    chk(S_BUS, 8'h3C, "i1_capture"); chk(S_STB, 8'h00, "i1_no_strobe");
    I1_bus_output_en = 1'b0; I0_bus_input_en = 1'b1; tick();
    chk(S_IO0, 8'h3C, "i0_load"); chk(S_STB, 8'h01, "strobe_first");
    tick();
    chk(S_IO0, 8'h3C, "i0_hold"); chk(S_STB, 8'h00, "strobe_once");
    idle(); tick();

    // Bank move: source still asserted while addr switches to destination
    bus_register_out_en = 1'b1; register_addr = 6'd2; tick();
    chk(S_BUS, 8'h5A, "mov_src_capture");
    register_addr = 6'd4; bus_register_input_en = 1'b1; dbg_addr = 6'd4; tick();
    chk(S_BUS, 8'h5A, "mov_bus_hold"); chk(S_DBG, 8'h5A, "mov_bank4");
    idle(); dbg_addr = 6'd2; tick();
    chk(S_DBG, 8'h5A, "mov_bank2_kept"); chk(S_AERR, 8'h00, "mov_no_addr_err");

    // Contention: hold kept, I0 write still happens with the held value
    bus_register_out_en = 1'b1; register_addr = 6'd0; I0_bus_output_en = 1'b1; I0_bus_input_en = 1'b1;
    tick();
    chk(S_BERR, 8'h01, "contention_flag"); chk(S_BUS, 8'h5A, "contention_hold");
    chk(S_IO0, 8'h5A, "contention_i0_write");
    idle(); tick();
    chk(S_BERR, 8'h01, "bus_err_sticky");
    bus_register_out_en = 1'b1; I1_bus_output_en = 1'b1; err_clear = 1'b1; tick();
    chk(S_BERR, 8'h01, "bus_err_set_wins");
    idle(); err_clear = 1'b1; tick();
    chk(S_BERR, 8'h00, "bus_err_cleared");
    idle(); tick();

    // Address errors: writes ignored (no aliasing), reads capture zero
    bus_register_input_en = 1'b1; register_addr = 6'd9; dbg_addr = 6'd1; tick();
    chk(S_AERR, 8'h01, "addr_err_wr9"); chk(S_DBG, 8'h00, "no_alias_bank1");
    register_addr = 6'd7; dbg_addr = 6'd7; tick();
    chk(S_DBG, 8'h00, "dbg_out_of_range");
    idle(); tick();
    bus_register_out_en = 1'b1; register_addr = 6'd6; tick();
    chk(S_BUS, 8'h00, "oor_read_zero"); chk(S_AERR, 8'h01, "addr_err_sticky");
    idle(); err_clear = 1'b1; tick();
    chk(S_AERR, 8'h00, "addr_err_cleared");
    idle(); tick();

    // Forwarding: same-cycle source rise and I0 load
    io1_in = 8'h11; tick();
    I1_bus_output_en = 1'b1; bus_register_input_en = 1'b1; register_addr = 6'd1; dbg_addr = 6'd1; tick();
    chk(S_DBG, 8'h11, "preload_bank1");
    idle(); tick();
    bus_register_out_en = 1'b1; register_addr = 6'd0; tick();
    chk(S_BUS, 8'h00, "bus_from_bank0");
    idle(); tick();
    bus_register_out_en = 1'b1; register_addr = 6'd1; I0_bus_input_en = 1'b1; tick();
    chk(S_IO0, 8'h11, "forward_i0"); chk(S_BUS, 8'h11, "forward_bus"); chk(S_STB, 8'h01, "forward_strobe");
    idle(); tick();

    // Reset mid-transfer
    bus_register_out_en = 1'b1; register_addr = 6'd2; tick();
    chk(S_BUS, 8'h5A, "pre_reset_bus");
    bus_register_input_en = 1'b1; register_addr = 6'd3; I0_bus_input_en = 1'b1; dbg_addr = 6'd3;
    reset = 1'b1; tick();
    chk(S_BUS, 8'h00, "mid_rst_bus"); chk(S_IO0, 8'h00, "mid_rst_io0"); chk(S_STB, 8'h00, "mid_rst_strobe");
    chk(S_DBG, 8'h00, "mid_rst_no_write");
    reset = 1'b0; idle(); dbg_addr = 6'd2; tick();
    chk(S_DBG, 8'h00, "post_rst_bank2"); chk(S_BERR, 8'h00, "post_rst_berr");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
    if (sb_q.size() > 0) begin
      $display("FAIL drain: %0d checks never reached, expected 0", sb_q.size());
      $fatal(1, "scoreboard did not drain");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mov_bus_responder.md
Name: mov_bus_responder

Overview:
- Datapath-side responder to the MOV sequencer's bus-enable interface.
- Owns the general register bank, the I0 bidirectional port register and the I1 input port.
- Executes reads and writes on the shared internal bus from the sequencer's enables and register_addr.
- Replaces a tristate bus with a registered bus-hold value, and flags contention and address errors.

Parameters:
DATA_W, 8, bus and register width
NUM_REGS, 5, general registers at addresses 0..NUM_REGS-1
ADDR_W, 6, width of register_addr and dbg_addr

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
register_addr  input  ADDR_W  register select for the bank access
bus_register_out_en  input  1  selected register drives the bus (source)
bus_register_input_en  input  1  selected register loads from the bus (destination)
I0_bus_output_en  input  1  I0 input register drives the bus
I0_bus_input_en  input  1  I0 output register loads from the bus
I1_bus_output_en  input  1  I1 input register drives the bus
io0_in  input  DATA_W  external I0 pin value
io1_in  input  DATA_W  external I1 pin value
io0_out  output  DATA_W  I0 output register
io0_strobe  output  1  one-cycle pulse when io0_out is updated
bus_data  output  DATA_W  current bus-hold value
bus_error  output  1  sticky: more than one source enable active in the same cycle
addr_error  output  1  sticky: bank access with register_addr >= NUM_REGS
err_clear  input  1  clears both sticky error flags
dbg_addr  input  ADDR_W  debug read select
dbg_data  output  DATA_W  combinational bank[dbg_addr]; 0 if out of range

Behaviour:
- Reset (clock edge with reset=1):
  - bank, bus_hold, io0_out, both io sample registers, the src_en_d edge register and the in_en_d edge register all clear to 0.
  - io0_strobe=0, bus_error=0, addr_error=0.
  - Reset mid-transfer aborts it; no write occurs on the reset edge.
- Pin sampling: io0_in and io1_in are registered every cycle (io0_s, io1_s). A bus read returns the value sampled at the previous edge (1-cycle pin latency).
- Source capture (edge-triggered):
  - src_rise = an output enable that is 1 this cycle and was 0 last cycle (per enable, tracked in src_en_d).
  - Exactly one source enable active and it is rising: bus_next = that source's value (bank[register_addr], io0_s or io1_s); bus_hold <= bus_next.
  - While a source enable stays high, bus_hold is held. Changing register_addr while bus_register_out_en remains high does NOT re-read; this lets the sequencer switch register_addr to the destination while the source is still asserted.
  - Otherwise bus_next = bus_hold.
  - bus_data = bus_hold.
- Contention:
  - Two or more source enables active in one cycle: bus_error <= 1 and bus_hold is unchanged.
  - The bank/I0 write in that cycle still occurs, using bus_hold.
- Destination write (level):
  - Each cycle bus_register_input_en=1 with register_addr < NUM_REGS: bank[register_addr] <= bus_next. bus_next forwards a same-cycle source capture, so source-rise and destination-write in one cycle moves the new value.
  - Each cycle I0_bus_input_en=1: io0_out <= bus_next.
  - Both destinations may load in the same cycle (broadcast).
- io0_strobe: 1 for exactly one cycle after the edge where I0_bus_input_en rises (tracked in in_en_d). It is not repeated while the enable stays high.
- Address errors: a bank access (out_en or input_en) with register_addr >= NUM_REGS sets addr_error <= 1.
  - Out-of-range write: ignored.
  - Out-of-range read: captures 0.
- Error flags:
  - err_clear=1 clears both flags on that edge.
  - If a new error occurs in the same cycle as err_clear, set wins.
- Read/write of the same register in the same cycle: the write uses bus_next and the read captures the pre-write bank value.
- State summary: per-source enable edge registers plus bus_hold form the only sequencing state. No FSM; all behaviour is per-cycle from enable levels and edges.

Test Plan:
- Reset, then preload bank[2]=0x5A via the write path. Then out_en rise with addr=2; next cycle input_en with addr=4 while out_en still high -> bus_data=0x5A, bank[4]=0x5A, bank[2] unchanged.
- io1_in=0x3C, I1_bus_output_en rise; next cycle I0_bus_input_en for 2 cycles -> io0_out=0x3C, io0_strobe high exactly 1 cycle.
- bus_register_out_en and I0_bus_output_en rise together -> bus_error=1, bus_hold unchanged. err_clear -> bus_error=0 next cycle.
- input_en with register_addr=7 -> no bank change, addr_error=1. Out_en with addr=6 -> bus_data=0.
- Same-cycle out_en rise (addr=1, bank[1]=0x11) with I0_bus_input_en -> io0_out=0x11 at that edge (forwarding).
- Reset asserted mid-transfer (out_en high, input_en pending) -> all outputs 0 and no bank write at the reset edge.
